// File: rtl/ttl_gate_exerciser.sv
// Self-checking exerciser for a bank of identical combinational gates: walks every input vector,
// samples responses SETTLE clocks later against TRUTH, and accumulates fail flags and an error count.
module ttl_gate_exerciser #(
    parameter int CHANNELS = 4,
    parameter int INPUTS   = 2,
    parameter     TRUTH    = 4'b0001,
    parameter int SETTLE   = 3,
    parameter bit RZ       = 1'b1,
    parameter int ERRW     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [CHANNELS*INPUTS-1:0]   stim,
    input  logic [CHANNELS-1:0]          resp,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CHANNELS-1:0]          fail_mask,
    output logic [ERRW-1:0]              err_count,
    output logic [INPUTS-1:0]            vec
);

    localparam int NPAT = 2 ** INPUTS;
    localparam int NCHK = RZ ? (2 * NPAT - 1) : NPAT;
    localparam int SW   = $clog2(NCHK + 1);
    localparam int TW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW   = $clog2(CHANNELS + 1);
    localparam int AW   = ((ERRW > CW) ? ERRW : CW) + 1;

    localparam logic [NPAT-1:0] TRUTH_TBL = NPAT'(TRUTH);

    if (SETTLE < 1) begin : g_bad_settle
        $error("ttl_gate_exerciser: SETTLE must be at least 1");
    end
    if (INPUTS < 1 || INPUTS > 4) begin : g_bad_inputs
        $error("ttl_gate_exerciser: INPUTS must be in 1..4");
    end
    if ($bits(TRUTH) != NPAT) begin : g_bad_truth
        $error("ttl_gate_exerciser: TRUTH width must equal 2**INPUTS");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q;
    logic [SW-1:0]   step_q;
    logic [TW-1:0]   timer_q;

    logic [CHANNELS-1:0] mismatch;
    logic [CW-1:0]       pop;
    logic [AW-1:0]       err_sum;
    logic [ERRW-1:0]     err_next;
    logic [SW-1:0]       step_inc;
    logic [INPUTS-1:0]   vec_inc;

    // RZ=1 interleaves zeros: odd steps carry pattern (s+1)/2, even steps carry 0.
    function automatic logic [INPUTS-1:0] vec_of(input logic [SW-1:0] s);
        logic [SW-1:0] half;
        half = (s + SW'(1)) >> 1;
        if (RZ) begin
            return s[0] ? INPUTS'(half) : '0;
        end
        return INPUTS'(s);
    endfunction

    always_comb begin
        mismatch = resp ^ {CHANNELS{TRUTH_TBL[vec]}};
        pop      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pop = pop + CW'(mismatch[c]);
        end
        err_sum  = AW'(err_count) + AW'(pop);
        err_next = (err_sum > AW'({ERRW{1'b1}})) ? {ERRW{1'b1}} : err_sum[ERRW-1:0];
        step_inc = step_q + SW'(1);
        vec_inc  = vec_of(step_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= '0;
            timer_q   <= '0;
            stim      <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StRun;
                        step_q    <= '0;
                        timer_q   <= TW'(SETTLE - 1);
                        stim      <= '0;
                        vec       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_mask <= '0;
                        err_count <= '0;
                    end
                end
                StRun: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - TW'(1);
                    end else begin
                        fail_mask <= fail_mask | mismatch;
                        err_count <= err_next;
                        if (step_q == SW'(NCHK - 1)) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next == '0);
                            stim    <= '0;
                            vec     <= '0;
                        end else begin
                            step_q  <= step_inc;
                            timer_q <= TW'(SETTLE - 1);
                            vec     <= vec_inc;
                            stim    <= {CHANNELS{vec_inc}};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_gate_exerciser.sv
// Directed bench: three exerciser instances driving NOR, NAND and inverted-NOR gate models.
module tb_ttl_gate_exerciser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // dut0: defaults (RZ NOR), channel 2 can be forced low
    logic       start0 = 1'b0;
    logic [7:0] stim0;
    logic [3:0] resp0;
    logic       busy0, done0, pass0;
    logic [3:0] mask0;
    logic [7:0] err0;
    logic [1:0] vec0;
    logic       force2 = 1'b0;

    // dut1: RZ=0 NAND
    logic       start1 = 1'b0;
    logic [7:0] stim1;
    logic [3:0] resp1;
    logic       busy1, done1, pass1;
    logic [3:0] mask1;
    logic [7:0] err1;
    logic [1:0] vec1;

    // dut2: ERRW=2, every response inverted
    logic       start2 = 1'b0;
    logic [7:0] stim2;
    logic [3:0] resp2;
    logic       busy2, done2, pass2;
    logic [3:0] mask2;
    logic [1:0] err2;
    logic [1:0] vec2;

    always_comb begin
        resp0 = '0;
        resp1 = '0;
        resp2 = '0;
        for (int c = 0; c < 4; c++) begin
            resp0[c] = (force2 && c == 2) ? 1'b0 : ~|stim0[c*2 +: 2];
            resp1[c] = ~&stim1[c*2 +: 2];
            resp2[c] = |stim2[c*2 +: 2];
        end
    end

    ttl_gate_exerciser u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .stim(stim0), .resp(resp0), .busy(busy0),
        .done(done0), .pass(pass0), .fail_mask(mask0), .err_count(err0), .vec(vec0)
    );

    ttl_gate_exerciser #(.RZ(1'b0), .TRUTH(4'b0111)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stim(stim1), .resp(resp1), .busy(busy1),
        .done(done1), .pass(pass1), .fail_mask(mask1), .err_count(err1), .vec(vec1)
    );

    ttl_gate_exerciser #(.ERRW(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stim(stim2), .resp(resp2), .busy(busy2),
        .done(done2), .pass(pass2), .fail_mask(mask2), .err_count(err2), .vec(vec2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start0 and count clocks until busy drops; optional re-pulses mid-run.
    task automatic run0(input bit repulse, output int cyc);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cyc = 0;
        while (busy0 && cyc < 100) begin
            if (repulse && (cyc == 4 || cyc == 19)) start0 = 1'b1;
            tick();
            start0 = 1'b0;
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_pass", pass0, 0);
        check_eq("rst_stim", stim0, 0);
        check_eq("rst_err",  err0, 0);
        check_eq("rst_mask", mask0, 0);

        // Test 1: healthy NOR bank, plus a peek at the RZ vector order
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check_eq("t1_busy_e0", busy0, 1);
        check_eq("t1_vec_e0", vec0, 0);
        repeat (3) tick();
        check_eq("t1_vec_e3", vec0, 1);
        check_eq("t1_stim_e3", stim0, 8'h55);
        repeat (3) tick();
        check_eq("t1_vec_e6", vec0, 0);
        repeat (3) tick();
        check_eq("t1_vec_e9", vec0, 2);
        cyc = 9;
        while (busy0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("t1_cycles", cyc, 21);
        check_eq("t1_done", done0, 1);
        check_eq("t1_pass", pass0, 1);
        check_eq("t1_mask", mask0, 0);
        check_eq("t1_err", err0, 0);
        check_eq("t1_stim_end", stim0, 0);
        repeat (4) tick();
        check_eq("t1_done_held", done0, 1);

        // Test 2: channel 2 stuck low fails only on the four zero vectors
        force2 = 1'b1;
        run0(1'b0, cyc);
        check_eq("t2_cycles", cyc, 21);
        check_eq("t2_mask", mask0, 4'b0100);
        check_eq("t2_err", err0, 4);
        check_eq("t2_pass", pass0, 0);
        check_eq("t2_done", done0, 1);

        // Test 6 (part): start in DONE clears stale results immediately
        force2 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check_eq("t6_clr_err", err0, 0);
        check_eq("t6_clr_mask", mask0, 0);
        check_eq("t6_clr_done", done0, 0);
        check_eq("t6_clr_busy", busy0, 1);
        cyc = 0;
        while (busy0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("t6_first_pass", pass0, 1);

        // Test 6: start re-pulsed mid-run is ignored
        run0(1'b1, cyc);
        check_eq("t6_cycles", cyc, 21);
        check_eq("t6_pass", pass0, 1);
        check_eq("t6_err", err0, 0);

        // Test 3: NAND bank, RZ off, straight 00,01,10,11 walk
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_eq("t3_stim_00", stim1, 8'h00);
        repeat (3) tick();
        check_eq("t3_stim_01", stim1, 8'h55);
        repeat (2) tick();
        check_eq("t3_stim_01_held", stim1, 8'h55);
        tick();
        check_eq("t3_stim_10", stim1, 8'hAA);
        repeat (3) tick();
        check_eq("t3_stim_11", stim1, 8'hFF);
        check_eq("t3_vec_11", vec1, 3);
        repeat (2) tick();
        check_eq("t3_busy_e11", busy1, 1);
        tick();
        check_eq("t3_done_e12", done1, 1);
        check_eq("t3_busy_e12", busy1, 0);
        check_eq("t3_pass", pass1, 1);
        check_eq("t3_stim_end", stim1, 0);

        // Test 4: inverted responses saturate a 2-bit counter
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (3) tick();
        check_eq("t4_err_first", err2, 3);
        cyc = 3;
        while (busy2 && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("t4_cycles", cyc, 21);
        check_eq("t4_err_sat", err2, 3);
        check_eq("t4_mask", mask2, 4'hF);
        check_eq("t4_pass", pass2, 0);

        // Test 5: reset at clock 10 of a run discards partial results
        force2 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (9) tick();
        check_eq("t5_err_partial", err0, 2);
        rst = 1'b1;
        start0 = 1'b1;
        tick();
        rst = 1'b0;
        start0 = 1'b0;
        force2 = 1'b0;
        check_eq("t5_busy", busy0, 0);
        check_eq("t5_done", done0, 0);
        check_eq("t5_err", err0, 0);
        check_eq("t5_mask", mask0, 0);
        check_eq("t5_stim", stim0, 0);
        check_eq("t5_vec", vec0, 0);
        tick();
        check_eq("t5_idle_busy", busy0, 0);
        run0(1'b0, cyc);
        check_eq("t5_cycles", cyc, 21);
        check_eq("t5_pass", pass0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
